controle_partida_cl: RTL and testbench

- Parametrised round/score controller for the chess-lab game: N players take turns guessing a target square (row/column) fetched from an external target ROM.
- Each move is compared, scored to the current player, and the turn rotates; a per-move timeout counts as a miss.
- Sits between the input synchroniser and the 7-segment/debug logic.
- Generalises the fixed two-player, 3-bit-board controller with configurable board size, player count, score width, round limit and timeout.

---
 rtl/controle_partida_cl.sv | 191 +++++++++++++++++++
 tb/tb_controle_partida_cl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_partida_cl.sv
// Round/score controller for the chess-lab game: N players take turns guessing ROM target squares.
// A rising temJogada edge produces acertou/errou two cycles later; terminar overrides every transition outside INICIAL/FIM.
module controle_partida_cl #(
    parameter int N_BITS      = 3,
    parameter int N_JOGADORES = 2,
    parameter int PONTOS_BITS = 4,
    parameter int ADDR_BITS   = 4,
    parameter int MAX_RODADAS = 16,
    parameter int TIMEOUT     = 30000
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 iniciar,
    input  logic                                 terminar,
    input  logic                                 temJogada,
    input  logic [N_BITS-1:0]                    jogadaFileira,
    input  logic [N_BITS-1:0]                    jogadaColuna,
    input  logic [N_BITS-1:0]                    alvo_linha,
    input  logic [N_BITS-1:0]                    alvo_coluna,
    output logic [ADDR_BITS-1:0]                 endereco_alvo,
    output logic [N_JOGADORES*PONTOS_BITS-1:0]   pontos,
    output logic [2:0]                           jogador_atual,
    output logic                                 acertou,
    output logic                                 errou,
    output logic                                 timeout,
    output logic                                 pronto,
    output logic [N_BITS-1:0]                    linhaEsperada,
    output logic [N_BITS-1:0]                    colunaEsperada,
    output logic [3:0]                           db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        BUSCA   = 4'd1,
        CARREGA = 4'd2,
        ESPERA  = 4'd3,
        COMPARA = 4'd4,
        ACERTO  = 4'd5,
        ERRO    = 4'd6,
        PROXIMO = 4'd7,
        FIM     = 4'd15
    } estado_t;

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int RW = ADDR_BITS + 1;
    localparam logic [TW-1:0]          TIMER_MAX  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]          TIMER_UM   = TW'(1);
    localparam logic [RW-1:0]          RODADA_FIM = RW'(MAX_RODADAS);
    localparam logic [RW-1:0]          RODADA_UM  = RW'(1);
    localparam logic [2:0]             ULTIMO     = 3'(N_JOGADORES - 1);
    localparam logic [PONTOS_BITS-1:0] PONTO_MAX  = '1;
    localparam logic [PONTOS_BITS-1:0] PONTO_UM   = PONTOS_BITS'(1);

    estado_t                            r_estado;
    estado_t                            w_prox_estado;
    logic                               r_tem_ant;
    logic                               r_por_timeout;
    logic [TW-1:0]                      r_timer;
    logic [RW-1:0]                      r_rodada;
    logic [2:0]                         r_jogador;
    logic [N_JOGADORES*PONTOS_BITS-1:0] r_pontos;
    logic [N_BITS-1:0]                  r_esp_linha;
    logic [N_BITS-1:0]                  r_esp_coluna;
    logic [N_BITS-1:0]                  r_jog_linha;
    logic [N_BITS-1:0]                  r_jog_coluna;

    logic                               w_borda;
    logic                               w_expirou;
    logic                               w_forca_fim;
    logic                               w_novo_jogo;
    logic                               w_acerto;
    logic [RW-1:0]                      w_rodada_prox;

    // The edge detector runs in every state, so a strobe that rises outside ESPERA is consumed there.
    assign w_borda       = temJogada & ~r_tem_ant;
    assign w_expirou     = (r_timer == TIMER_MAX);
    assign w_forca_fim   = terminar && (r_estado != INICIAL) && (r_estado != FIM);
    assign w_novo_jogo   = iniciar && ((r_estado == INICIAL) || (r_estado == FIM));
    assign w_acerto      = (r_jog_linha == r_esp_linha) && (r_jog_coluna == r_esp_coluna);
    assign w_rodada_prox = r_rodada + RODADA_UM;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            INICIAL: if (iniciar) w_prox_estado = BUSCA;
            BUSCA:   w_prox_estado = CARREGA;
            CARREGA: w_prox_estado = ESPERA;
            ESPERA: begin
                if (w_borda) begin
                    w_prox_estado = COMPARA;
                end else if (w_expirou) begin
                    w_prox_estado = ERRO;
                end
            end
            COMPARA: w_prox_estado = w_acerto ? ACERTO : ERRO;
            ACERTO:  w_prox_estado = PROXIMO;
            ERRO:    w_prox_estado = PROXIMO;
            PROXIMO: w_prox_estado = (w_rodada_prox == RODADA_FIM) ? FIM : BUSCA;
            FIM:     if (iniciar) w_prox_estado = BUSCA;
            default: w_prox_estado = INICIAL;
        endcase
        if (w_forca_fim) begin
            w_prox_estado = FIM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tem_ant     <= 1'b0;
            r_por_timeout <= 1'b0;
            r_timer       <= '0;
            r_rodada      <= '0;
            r_jogador     <= '0;
            r_pontos      <= '0;
            r_esp_linha   <= '0;
            r_esp_coluna  <= '0;
            r_jog_linha   <= '0;
            r_jog_coluna  <= '0;
        end else begin
            r_tem_ant     <= temJogada;
            r_por_timeout <= (r_estado == ESPERA) && w_expirou && !w_borda;
            if (w_novo_jogo) begin
                r_pontos  <= '0;
                r_rodada  <= '0;
                r_jogador <= '0;
            end else if (!w_forca_fim) begin
                // Gating on terminar is what drops an ACERTO increment that coincides with it.
                case (r_estado)
                    CARREGA: begin
                        r_esp_linha  <= alvo_linha;
                        r_esp_coluna <= alvo_coluna;
                        r_timer      <= '0;
                    end
                    ESPERA: begin
                        r_timer <= r_timer + TIMER_UM;
                        if (w_borda) begin
                            r_jog_linha  <= jogadaFileira;
                            r_jog_coluna <= jogadaColuna;
                        end
                    end
                    ACERTO: begin
                        for (int k = 0; k < N_JOGADORES; k++) begin
                            if ((r_jogador == 3'(k)) &&
                                (r_pontos[k*PONTOS_BITS +: PONTOS_BITS] != PONTO_MAX)) begin
                                r_pontos[k*PONTOS_BITS +: PONTOS_BITS] <=
                                    r_pontos[k*PONTOS_BITS +: PONTOS_BITS] + PONTO_UM;
                            end
                        end
                    end
                    PROXIMO: begin
                        r_rodada  <= w_rodada_prox;
                        r_jogador <= (r_jogador == ULTIMO) ? 3'd0 : r_jogador + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        acertou = 1'b0;
        errou   = 1'b0;
        timeout = 1'b0;
        pronto  = 1'b0;
        case (r_estado)
            ACERTO: acertou = 1'b1;
            ERRO: begin
                errou   = 1'b1;
                timeout = r_por_timeout;
            end
            FIM:    pronto = 1'b1;
            default: ;
        endcase
    end

    assign endereco_alvo  = r_rodada[ADDR_BITS-1:0];
    assign pontos         = r_pontos;
    assign jogador_atual  = r_jogador;
    assign linhaEsperada  = r_esp_linha;
    assign colunaEsperada = r_esp_coluna;
    assign db_estado      = r_estado;

endmodule

// File: tb/tb_controle_partida_cl.sv
// Bench for controle_partida_cl: instance 0 has default sizing with a 20-cycle move timer,
// instance 1 has three players with 2-bit scores; both are checked every cycle against a timeline model.
module tb_controle_partida_cl;

    localparam int NC   = 4096;
    localparam int MAXR = 16;

    function automatic int nj(input int d);
        return (d == 0) ? 2 : 3;
    endfunction
    function automatic int pb(input int d);
        return (d == 0) ? 4 : 2;
    endfunction
    function automatic int tmo(input int d);
        return (d == 0) ? 20 : 30000;
    endfunction

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       t_rst [2];
    logic       t_ini [2];
    logic       t_ter [2];
    logic       t_tem [2];
    logic [2:0] t_fil [2];
    logic [2:0] t_col [2];
    logic [2:0] t_alin[2];
    logic [2:0] t_acol[2];
    logic [3:0] d_end [2];
    logic [2:0] d_jog [2];
    logic       d_ac  [2];
    logic       d_er  [2];
    logic       d_to  [2];
    logic       d_pr  [2];
    logic [2:0] d_le  [2];
    logic [2:0] d_ce  [2];
    logic [3:0] d_est [2];
    logic [7:0] pts_a;
    logic [5:0] pts_b;

    controle_partida_cl #(.TIMEOUT(20)) dut_a (
        .clock(clk), .reset(t_rst[0]), .iniciar(t_ini[0]), .terminar(t_ter[0]),
        .temJogada(t_tem[0]), .jogadaFileira(t_fil[0]), .jogadaColuna(t_col[0]),
        .alvo_linha(t_alin[0]), .alvo_coluna(t_acol[0]), .endereco_alvo(d_end[0]),
        .pontos(pts_a), .jogador_atual(d_jog[0]), .acertou(d_ac[0]), .errou(d_er[0]),
        .timeout(d_to[0]), .pronto(d_pr[0]), .linhaEsperada(d_le[0]),
        .colunaEsperada(d_ce[0]), .db_estado(d_est[0])
    );

    controle_partida_cl #(.N_JOGADORES(3), .PONTOS_BITS(2)) dut_b (
        .clock(clk), .reset(t_rst[1]), .iniciar(t_ini[1]), .terminar(t_ter[1]),
        .temJogada(t_tem[1]), .jogadaFileira(t_fil[1]), .jogadaColuna(t_col[1]),
        .alvo_linha(t_alin[1]), .alvo_coluna(t_acol[1]), .endereco_alvo(d_end[1]),
        .pontos(pts_b), .jogador_atual(d_jog[1]), .acertou(d_ac[1]), .errou(d_er[1]),
        .timeout(d_to[1]), .pronto(d_pr[1]), .linhaEsperada(d_le[1]),
        .colunaEsperada(d_ce[1]), .db_estado(d_est[1])
    );

    // Target ROMs with one cycle of read latency.
    int rom_l[2][16];
    int rom_c[2][16];
    always @(posedge clk) begin
        t_alin[0] <= 3'(rom_l[0][d_end[0]]);
        t_acol[0] <= 3'(rom_c[0][d_end[0]]);
        t_alin[1] <= 3'(rom_l[1][d_end[1]]);
        t_acol[1] <= 3'(rom_c[1][d_end[1]]);
    end

    // Model: game state plus per-cycle expected outputs (pulse code: 1 hit, 2 miss, 6 timeout miss).
    int m_pts[2][8];
    int m_jog[2];
    int m_round[2];
    int m_esp[2];
    int e_pulse[2][NC];
    int e_pts[2][NC];
    int e_jog[2][NC];
    int e_pr[2][NC];

    int n_asserts = 0;
    int n_fail    = 0;
    bit chk_en    = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_asserts++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int packed_pts(input int d);
        int s = 0;
        for (int k = 0; k < nj(d); k++) s += m_pts[d][k] << (k * pb(d));
        return s;
    endfunction

    task automatic fill_pts(input int d, input int c);
        for (int i = c; i < NC; i++) e_pts[d][i] = packed_pts(d);
    endtask
    task automatic fill_jog(input int d, input int c);
        for (int i = c; i < NC; i++) e_jog[d][i] = m_jog[d];
    endtask
    task automatic fill_pr(input int d, input int c, input int v);
        for (int i = c; i < NC; i++) e_pr[d][i] = v;
    endtask

    function automatic int act_pulse(input int d);
        return int'({d_to[d], d_er[d], d_ac[d]});
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("pulse%0d", d), act_pulse(d), e_pulse[d][cyc]);
                chk($sformatf("pontos%0d", d), (d == 0) ? int'(pts_a) : int'(pts_b), e_pts[d][cyc]);
                chk($sformatf("jogador%0d", d), int'(d_jog[d]), e_jog[d][cyc]);
                chk($sformatf("pronto%0d", d), int'(d_pr[d]), e_pr[d][cyc]);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        for (int g = 0; g < NC && cyc < c; g++) step();
    endtask

    task automatic start_game(input int d, input int hold);
        int s;
        s = cyc;
        t_ini[d] = 1'b1;
        for (int k = 0; k < 8; k++) m_pts[d][k] = 0;
        m_jog[d]   = 0;
        m_round[d] = 0;
        fill_pts(d, s + 1);
        fill_jog(d, s + 1);
        fill_pr(d, s + 1, 0);
        m_esp[d] = s + 3;
        repeat (hold) step();
        t_ini[d] = 1'b0;
    endtask

    task automatic play(input int d, input int row, input int coluna, input int hold,
                        input bit kill, output int lp);
        int p;
        int j;
        bit hit;
        wait_to(m_esp[d]);
        p = cyc;
        t_fil[d] = 3'(row);
        t_col[d] = 3'(coluna);
        t_tem[d] = 1'b1;
        hit = (row == rom_l[d][m_round[d]]) && (coluna == rom_c[d][m_round[d]]);
        e_pulse[d][p + 2] = hit ? 1 : 2;
        j = m_jog[d];
        if (kill) begin
            fill_pr(d, p + 3, 1);
        end else begin
            if (hit && m_pts[d][j] < (1 << pb(d)) - 1) m_pts[d][j]++;
            fill_pts(d, p + 3);
            m_jog[d] = (j + 1) % nj(d);
            m_round[d]++;
            fill_jog(d, p + 4);
            if (m_round[d] == MAXR) fill_pr(d, p + 4, 1);
            else m_esp[d] = p + 6;
        end
        lp = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 1) begin
                t_fil[d] = ~t_fil[d];
                t_col[d] = ~t_col[d];
            end
            if (i >= hold) t_tem[d] = 1'b0;
            t_ter[d] = kill && (i == 2);
            if (i == 2) lp = act_pulse(d);
        end
    endtask

    task automatic timeout_move(input int d, output int lp);
        int e;
        int t;
        e = m_esp[d];
        t = tmo(d);
        e_pulse[d][e + t] = 6;
        m_jog[d] = (m_jog[d] + 1) % nj(d);
        m_round[d]++;
        fill_jog(d, e + t + 2);
        if (m_round[d] == MAXR) fill_pr(d, e + t + 2, 1);
        else m_esp[d] = e + t + 4;
        wait_to(e + t);
        lp = act_pulse(d);
    endtask

    task automatic terminate_now(input int d);
        wait_to(m_esp[d]);
        t_ter[d] = 1'b1;
        fill_pr(d, cyc + 1, 1);
        step();
        t_ter[d] = 1'b0;
    endtask

    // Strobe raised before ESPERA and held into it: must not count as a move.
    task automatic ghost(input int d);
        t_tem[d] = 1'b1;
        wait_to(m_esp[d] + 2);
        t_tem[d] = 1'b0;
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: summary not reached by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lp;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                rom_l[d][i] = (i * 5 + d) % 8;
                rom_c[d][i] = (i * 3 + 1) % 8;
            end
            for (int i = 0; i < NC; i++) begin
                e_pulse[d][i] = 0;
                e_pts[d][i]   = 0;
                e_jog[d][i]   = 0;
                e_pr[d][i]    = 0;
            end
            t_rst[d] = 1'b1;
            t_ini[d] = 1'b0;
            t_ter[d] = 1'b0;
            t_tem[d] = 1'b0;
            t_fil[d] = 3'd0;
            t_col[d] = 3'd0;
            m_esp[d] = 0;
        end
        rom_l[0][0] = 0; rom_c[0][0] = 1;
        rom_l[0][1] = 1; rom_c[0][1] = 1;
        chk_en = 1'b1;

        step();
        step();
        chk("reset_estado", int'(d_est[0]), 0);
        chk("reset_linha", int'(d_le[0]), 0);
        chk("reset_endereco", int'(d_end[1]), 0);
        t_rst[0] = 1'b0;
        t_rst[1] = 1'b0;
        step();

        // Game 1 on instance 0: hit, miss, timeout, forced end.
        start_game(0, 5);
        play(0, 0, 1, 2, 1'b0, lp);
        chk("hit_pulse", lp, 1);
        chk("hit_pontos", int'(pts_a), 8'h01);
        chk("hit_jogador", int'(d_jog[0]), 1);
        chk("hit_linha_esp", int'(d_le[0]), 0);
        chk("hit_coluna_esp", int'(d_ce[0]), 1);
        play(0, 1, 0, 1, 1'b0, lp);
        chk("miss_pulse", lp, 2);
        chk("miss_pontos", int'(pts_a), 8'h01);
        chk("miss_jogador", int'(d_jog[0]), 0);
        chk("miss_coluna_esp", int'(d_ce[0]), 1);
        timeout_move(0, lp);
        chk("timeout_pulse", lp, 6);
        wait_to(m_esp[0]);
        chk("timeout_jogador", int'(d_jog[0]), 1);
        terminate_now(0);
        chk("term_estado", int'(d_est[0]), 15);
        chk("term_pontos", int'(pts_a), 8'h01);

        // Restart from FIM, then terminar landing on ACERTO drops the point.
        start_game(0, 1);
        chk("restart_pontos", int'(pts_a), 0);
        chk("restart_endereco", int'(d_end[0]), 0);
        chk("restart_estado", int'(d_est[0]), 1);
        play(0, rom_l[0][0], rom_c[0][0], 1, 1'b1, lp);
        chk("kill_pulse", lp, 1);
        chk("kill_pontos", int'(pts_a), 0);
        chk("kill_estado", int'(d_est[0]), 15);

        // Player 0 reaches 3, then an asynchronous reset in ESPERA.
        start_game(0, 1);
        for (int r = 0; r < 5; r++) begin
            if (r % 2 == 0) play(0, rom_l[0][r], rom_c[0][r], 1, 1'b0, lp);
            else play(0, rom_l[0][r], (rom_c[0][r] + 1) % 8, 1, 1'b0, lp);
        end
        wait_to(m_esp[0]);
        chk("pre_reset_pontos", int'(pts_a), 8'h03);
        chk("pre_reset_estado", int'(d_est[0]), 3);
        t_rst[0] = 1'b1;
        for (int k = 0; k < 8; k++) m_pts[0][k] = 0;
        m_jog[0] = 0;
        m_round[0] = 0;
        fill_pts(0, cyc);
        fill_jog(0, cyc);
        fill_pr(0, cyc, 0);
        #1;
        chk("async_reset_estado", int'(d_est[0]), 0);
        step();
        chk("reset_mid_estado", int'(d_est[0]), 0);
        chk("reset_mid_pontos", int'(pts_a), 0);
        chk("reset_mid_jogador", int'(d_jog[0]), 0);
        chk("reset_mid_pronto", int'(d_pr[0]), 0);
        t_rst[0] = 1'b0;
        step();

        // Instance 1: ignored early strobe, then 16 correct moves with saturation.
        start_game(1, 1);
        ghost(1);
        for (int r = 0; r < MAXR; r++) begin
            play(1, rom_l[1][r], rom_c[1][r], 1, 1'b0, lp);
            chk($sformatf("b_hit_r%0d", r), lp, 1);
        end
        chk("b_pronto", int'(d_pr[1]), 1);
        chk("b_estado", int'(d_est[1]), 15);
        chk("b_pontos_sat", int'(pts_b), 6'h3F);
        chk("b_jogador", int'(d_jog[1]), 1);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
